// File: rtl/fm_sb_freeze_ctrl.sv
// fm_sb_freeze_ctrl
// Freeze/playback sequencer for the FM spy-buffer array (AXI control domain).
// Turns register-level controls into per-buffer freeze and playback-mode
// vectors. Supports a level global freeze, a delayed hardware trigger,
// explicit re-arm, and a timed spy-memory initialisation strobe.
//
// Optional feature macro: FM_SB_TRIG_CNT_EN (accepted-trigger counter on
// trig_cnt_o; when undefined trig_cnt_o is tied to zero).
//
// Ports:
//   axi_clk            clock
//   axi_rst            synchronous active-high reset
//   global_freeze_i    level, forces freeze while high
//   freeze_trig_i      single-cycle hardware trigger
//   freeze_delay_i     trigger-to-freeze delay, sampled on acceptance
//   rearm_i            pulse, releases a held freeze
//   init_req_i         level, rising edge starts initialisation
//   freeze_mask_i      per-buffer freeze exclusion
//   playback_mask_i    per-buffer playback-mode force-to-zero
//   global_pb_mode_i   mode for unmasked buffers
//   freeze_o           per-buffer freeze
//   playback_mode_o    flat per-buffer mode, buffer i at [i*PB_MODE_W +: PB_MODE_W]
//   init_spy_mem_o     initialisation strobe
//   state_o            IDLE=0, DELAY=1, FROZEN=2, INIT=3
//   trig_cnt_o         accepted-trigger count
module fm_sb_freeze_ctrl #(
  parameter int unsigned SB_N        = 64,
  parameter int unsigned PB_MODE_W   = 2,
  parameter int unsigned DELAY_W     = 16,
  parameter int unsigned INIT_CYCLES = 1024
) (
  input  logic                        axi_clk,
  input  logic                        axi_rst,
  input  logic                        global_freeze_i,
  input  logic                        freeze_trig_i,
  input  logic [DELAY_W-1:0]          freeze_delay_i,
  input  logic                        rearm_i,
  input  logic                        init_req_i,
  input  logic [SB_N-1:0]             freeze_mask_i,
  input  logic [SB_N-1:0]             playback_mask_i,
  input  logic [PB_MODE_W-1:0]        global_pb_mode_i,
  output logic [SB_N-1:0]             freeze_o,
  output logic [SB_N*PB_MODE_W-1:0]   playback_mode_o,
  output logic                        init_spy_mem_o,
  output logic [1:0]                  state_o,
  output logic [15:0]                 trig_cnt_o
);

  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    FROZEN = 2'd2,
    INIT   = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [DELAY_W-1:0]          dly_q, dly_d;
  logic [IW-1:0]               icnt_q, icnt_d;
  logic                        init_req_q;
  logic                        init_edge;
  logic [SB_N-1:0]             freeze_q, freeze_d;
  logic [SB_N*PB_MODE_W-1:0]   pb_q, pb_d;
  logic                        init_o_q;

  assign init_edge = init_req_i & ~init_req_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    icnt_d  = icnt_q;
    if (init_edge) begin
      state_d = INIT;
      icnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (global_freeze_i) begin
            state_d = FROZEN;
          end else if (freeze_trig_i) begin
            if (freeze_delay_i == '0) begin
              state_d = FROZEN;
            end else begin
              state_d = DELAY;
              dly_d   = freeze_delay_i;
            end
          end
        end
        DELAY: begin
          dly_d = dly_q - DELAY_W'(1);
          if (global_freeze_i || dly_q == DELAY_W'(1)) state_d = FROZEN;
        end
        FROZEN: begin
          if (rearm_i && !global_freeze_i) state_d = IDLE;
        end
        INIT: begin
          if (icnt_q == INIT_LAST) state_d = IDLE;
          else                     icnt_d  = icnt_q + IW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_o
  // changes and still respond to mask/mode inputs one cycle later.
  always_comb begin
    freeze_d = '0;
    pb_d     = '0;
    for (int unsigned i = 0; i < SB_N; i++) begin
      freeze_d[i] = (state_d == FROZEN) & ~freeze_mask_i[i];
      if (!playback_mask_i[i] && state_d != INIT)
        pb_d[i*PB_MODE_W +: PB_MODE_W] = global_pb_mode_i;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      icnt_q     <= '0;
      init_req_q <= 1'b0;
      freeze_q   <= '0;
      pb_q       <= '0;
      init_o_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      icnt_q     <= icnt_d;
      init_req_q <= init_req_i;
      freeze_q   <= freeze_d;
      pb_q       <= pb_d;
      init_o_q   <= (state_d == INIT);
    end
  end

  assign freeze_o        = freeze_q;
  assign playback_mode_o = pb_q;
  assign init_spy_mem_o  = init_o_q;
  assign state_o         = state_q;

`ifdef FM_SB_TRIG_CNT_EN
  logic        trig_accept;
  logic [15:0] trig_cnt_q;

  // Mirrors the IDLE trigger-acceptance branch of the next-state logic.
  assign trig_accept = ~init_edge & (state_q == IDLE) & ~global_freeze_i & freeze_trig_i;

  always_ff @(posedge axi_clk) begin
    if (axi_rst || rearm_i)                  trig_cnt_q <= '0;
    else if (trig_accept && trig_cnt_q != '1) trig_cnt_q <= trig_cnt_q + 16'd1;
  end

  assign trig_cnt_o = trig_cnt_q;
`else
  assign trig_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fm_sb_freeze_ctrl.sv
module tb_fm_sb_freeze_ctrl;

  localparam int unsigned N  = 40;
  localparam int unsigned PW = 2;
  localparam int unsigned DW = 16;

  localparam logic [N-1:0] M  = 40'h00_0000_00F0;
  localparam logic [N-1:0] FZ = 40'hFF_FFFF_FF0F;
  localparam logic [N-1:0] AL = 40'hFF_FFFF_FFFF;
  localparam logic [N-1:0] P3 = 40'h00_0000_0008;

  logic              clk = 1'b0;
  logic              rst, gf, trig, rearm, init;
  logic [DW-1:0]     dly;
  logic [N-1:0]      fmask, pmask;
  logic [PW-1:0]     mode;
  logic [N-1:0]      freeze_o;
  logic [N*PW-1:0]   pb_o;
  logic              init_o;
  logic [1:0]        state_o;
  logic [15:0]       tc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fm_sb_freeze_ctrl #(
    .SB_N(N), .PB_MODE_W(PW), .DELAY_W(DW), .INIT_CYCLES(4)
  ) dut (
    .axi_clk(clk), .axi_rst(rst),
    .global_freeze_i(gf), .freeze_trig_i(trig), .freeze_delay_i(dly),
    .rearm_i(rearm), .init_req_i(init),
    .freeze_mask_i(fmask), .playback_mask_i(pmask), .global_pb_mode_i(mode),
    .freeze_o(freeze_o), .playback_mode_o(pb_o), .init_spy_mem_o(init_o),
    .state_o(state_o), .trig_cnt_o(tc_o)
  );

  typedef struct {
    logic          rst, gf, tr, rearm, init;
    logic [DW-1:0] dly;
    logic [N-1:0]  fm, pm;
    logic [PW-1:0] mode;
    logic [N-1:0]  efz;
    logic [1:0]    est;
    logic          eio;
    logic [PW-1:0] epbm;   // expected mode on unmasked buffers
    logic [15:0]   etc;    // expected trigger count when counter is built
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, g, t, ra, in, input logic [DW-1:0] d,
                     input logic [N-1:0] fm, pm, input logic [PW-1:0] md,
                     input logic [N-1:0] efz, input logic [1:0] est,
                     input logic eio, input logic [PW-1:0] epbm,
                     input logic [15:0] etc);
    vec_t v;
    v.rst = r; v.gf = g; v.tr = t; v.rearm = ra; v.init = in; v.dly = d;
    v.fm = fm; v.pm = pm; v.mode = md; v.efz = efz; v.est = est;
    v.eio = eio; v.epbm = epbm; v.etc = etc;
    tbl.push_back(v);
  endtask

  function automatic logic [N*PW-1:0] pbexp(input logic [PW-1:0] md, input logic [N-1:0] pm);
    logic [N*PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (!pm[i]) r[i*PW +: PW] = md;
    return r;
  endfunction

  task automatic check(input string nm, input logic [N*PW-1:0] act, input logic [N*PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; gf = 0; trig = 0; rearm = 0; init = 0; dly = '0;
    fmask = M; pmask = '0; mode = 2'b01;

    //  rst gf tr ra in dly fmask pmask mode | freeze st io pbm tc
    add(1, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b00, 0);  // 0 reset
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b01, 0);  // 1 idle
    add(0, 1, 0, 0, 0, 0, M, 0, 2'b01, FZ, 2, 0, 2'b01, 0);  // 2 global freeze
    add(0, 1, 0, 0, 0, 0, M, 0, 2'b01, FZ, 2, 0, 2'b01, 0);  // 3 held
    add(0, 0, 0, 1, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b01, 0);  // 4 rearm
    add(0, 0, 1, 0, 0, 5, M, 0, 2'b01,  0, 1, 0, 2'b01, 1);  // 5 trig D=5 (T)
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 1, 0, 2'b01, 1);  // 6
    add(0, 0, 1, 0, 0, 1, M, 0, 2'b01,  0, 1, 0, 2'b01, 1);  // 7 trig at T+2 ignored
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 1, 0, 2'b01, 1);  // 8
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 1, 0, 2'b01, 1);  // 9  -> T+5
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01, FZ, 2, 0, 2'b01, 1);  // 10 -> T+6 frozen
    add(0, 0, 0, 1, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b01, 0);  // 11 rearm
    add(0, 0, 1, 0, 0, 0, M, 0, 2'b01, FZ, 2, 0, 2'b01, 1);  // 12 trig D=0
    add(0, 0, 1, 1, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b01, 0);  // 13 rearm+trig
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b01, 0);  // 14 no new freeze
    add(0, 1, 0, 0, 0, 0, M, 0, 2'b01, FZ, 2, 0, 2'b01, 0);  // 15 frozen
    add(0, 1, 0, 0, 1, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 16 init edge (T)
    add(0, 1, 1, 0, 1, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 17
    add(0, 0, 0, 0, 1, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 18
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 19 T+4
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b01, 0);  // 20 T+5 idle
    add(0, 0, 0, 0, 0, 0, M, P3, 2'b10, 0, 0, 0, 2'b10, 0);  // 21 pb mask bit 3
    add(0, 1, 0, 0, 0, 0, M, P3, 2'b10, FZ, 2, 0, 2'b10, 0); // 22 frozen
    add(0, 1, 0, 0, 0, 0, 0, P3, 2'b11, AL, 2, 0, 2'b11, 0); // 23 mode+mask change
    add(0, 0, 0, 1, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b01, 0);  // 24 rearm
    add(0, 0, 1, 0, 0, 5, M, 0, 2'b01,  0, 1, 0, 2'b01, 1);  // 25 trig D=5, cnt 5
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 1, 0, 2'b01, 1);  // 26 cnt 4
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 1, 0, 2'b01, 1);  // 27 cnt 3
    add(1, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b00, 0);  // 28 reset mid-delay
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 0, 0, 0, M, 0, 2'b01, 0, 0, 0, 2'b01, 0); // 29..33 never frozen
    add(0, 0, 0, 0, 1, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 34 init edge
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 35
    add(0, 0, 0, 0, 1, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 36 restart
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 37
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 38
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 3, 1, 2'b00, 0);  // 39
    add(0, 0, 0, 0, 0, 0, M, 0, 2'b01,  0, 0, 0, 2'b01, 0);  // 40 idle

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; gf = tbl[i].gf; trig = tbl[i].tr; rearm = tbl[i].rearm;
      init = tbl[i].init; dly = tbl[i].dly; fmask = tbl[i].fm; pmask = tbl[i].pm;
      mode = tbl[i].mode;
      @(posedge clk); #1;
      check($sformatf("v%0d freeze", i), {{(N*PW-N){1'b0}}, freeze_o}, {{(N*PW-N){1'b0}}, tbl[i].efz});
      check($sformatf("v%0d state", i), {{(N*PW-2){1'b0}}, state_o}, {{(N*PW-2){1'b0}}, tbl[i].est});
      check($sformatf("v%0d init", i), {{(N*PW-1){1'b0}}, init_o}, {{(N*PW-1){1'b0}}, tbl[i].eio});
      check($sformatf("v%0d pbmode", i), pb_o, pbexp(tbl[i].epbm, tbl[i].pm));
`ifdef FM_SB_TRIG_CNT_EN
      check($sformatf("v%0d trigcnt", i), {{(N*PW-16){1'b0}}, tc_o}, {{(N*PW-16){1'b0}}, tbl[i].etc});
`else
      check($sformatf("v%0d trigcnt", i), {{(N*PW-16){1'b0}}, tc_o}, '0);
`endif
    end

    // Trigger latency with D=3: freeze_o must first appear D+1 cycles later.
    rst = 0; gf = 0; rearm = 0; init = 0; fmask = '0; trig = 1; dly = 16'd3;
    @(posedge clk); #1;
    trig = 0; dly = '0;
    n = 1;
    while (freeze_o == '0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("trig_d3_latency", 80'(n), 80'd4);
    check("trig_d3_freeze", {{(N*PW-N){1'b0}}, freeze_o}, {{(N*PW-N){1'b0}}, AL});
    rearm = 1;
    @(posedge clk); #1;
    rearm = 0;
    check("trig_d3_release", {{(N*PW-N){1'b0}}, freeze_o}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
